// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and the hex-to-seven-segment decoder for the scan scheduler
package seg_pkg;
  localparam int DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_LUT [16] = '{
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
    8'b10011001, 8'b01001001, 8'b01000001, 8'b00011011,
    8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
    8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
  };
  function automatic logic [7:0] hex_to_7seg(input logic [3:0] h);
    return SEG_LUT[h];
  endfunction
endpackage

// File: rtl/seg_page_arbiter.sv
// seg_page_arbiter: round-robin search for the next valid source after the current page
module seg_page_arbiter #(
  parameter int NUM_SRC = 4,
  localparam int SW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] src_valid,
  input  logic [SW-1:0]      cur_page,
  output logic               found,
  output logic [SW-1:0]      next_page
);
  logic [2**SW-1:0] valid_x;
  // Nearest valid source after cur_page wins; fall back to staying put if only cur_page is valid
  always_comb begin
    valid_x = (2**SW)'(src_valid);
    found = valid_x[cur_page];
    next_page = cur_page;
    for (int i = NUM_SRC - 1; i >= 1; i--) begin
      if (valid_x[SW'((int'(cur_page) + i) % NUM_SRC)]) begin
        found = 1'b1;
        next_page = SW'((int'(cur_page) + i) % NUM_SRC);
      end
    end
  end
endmodule

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: 8-digit multiplexed display driver with frame-aligned source paging
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int PAGE_FRAMES = 512,
  parameter int NUM_SRC     = 4,
  localparam int SW = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [32*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic                  mode_auto,
  input  logic [SW-1:0]         manual_sel,
  input  logic                  freeze,
  output logic [SW-1:0]         page_sel,
  output logic                  frame_start,
  output logic [7:0]            display_data,
  output logic [7:0]            display_en
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = PAGE_FRAMES > 1 ? $clog2(PAGE_FRAMES) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int NP = 2**SW;
  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_i_n;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [FW-1:0]    fc_q, fc_d;
  logic [SW-1:0]    page_q, page_d, cand, arb_page;
  logic [31:0]      snap_q, snap_d;
  logic             blank_q, blank_d, mode_q, mode_d, fs_q, fs_d;
  logic [7:0]       dd_q, dd_d, den_q, den_d;
  logic             tick, bnd, upd, adv, cand_ok, arb_found;
  logic [NP-1:0]    valid_x;
  logic [32*NP-1:0] data_x;
  seg_page_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .src_valid (src_valid),
    .cur_page  (page_q),
    .found     (arb_found),
    .next_page (arb_page)
  );
  // Reset release is resynchronised so every scan flop leaves reset on the same edge
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
  // Reset synchroniser: asynchronous assert, clocked release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync_q <= '0;
    else rst_sync_q <= rst_sync_d;
  assign rst_i_n = rst_sync_q[1];
  // Scan timing, frame-boundary page selection and registered display decode
  always_comb begin
    valid_x = NP'(src_valid);
    data_x = (32*NP)'(src_data);
    tick = cnt_q == CW'(SCAN_DIV - 1);
    bnd = tick && idx_q == IW'(DIGITS - 1);
    upd = bnd && !freeze;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q + IW'(tick);
    adv = mode_auto && mode_q && fc_q == FW'(PAGE_FRAMES - 1);
    cand = !mode_auto ? manual_sel : adv ? arb_page : page_q;
    cand_ok = !mode_auto ? (int'(manual_sel) < NUM_SRC) && valid_x[manual_sel]
            : adv ? arb_found : valid_x[page_q];
    fc_d = !upd ? fc_q : (!(mode_auto && mode_q) || adv) ? '0 : fc_q + 1'b1;
    page_d = upd && cand_ok ? cand : page_q;
    snap_d = upd && cand_ok ? 32'(data_x >> {cand, 5'b0}) : snap_q;
    blank_d = upd ? !cand_ok : blank_q;
    mode_d = upd ? mode_auto : mode_q;
    fs_d = bnd;
    den_d = blank_q ? SEG_BLANK : ~(8'b1 << idx_q);
    dd_d = blank_q ? SEG_BLANK : hex_to_7seg(4'(snap_q >> {idx_q, 2'b00}));
  end
  // State registers, all cleared the moment reset asserts
  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      fc_q <= '0;
      page_q <= '0;
      snap_q <= '0;
      blank_q <= 1'b1;
      mode_q <= 1'b0;
      fs_q <= 1'b0;
      dd_q <= SEG_BLANK;
      den_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      fc_q <= fc_d;
      page_q <= page_d;
      snap_q <= snap_d;
      blank_q <= blank_d;
      mode_q <= mode_d;
      fs_q <= fs_d;
      dd_q <= dd_d;
      den_q <= den_d;
    end
  assign page_sel = page_q;
  assign frame_start = fs_q;
  assign display_data = dd_q;
  assign display_en = den_q;
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb_seg_scan_scheduler: frame-level scoreboard bench for the seven-segment scan scheduler
module tb_seg_scan_scheduler;
  localparam int SD = 4;
  localparam logic [31:0] W0 = 32'h01234567, W1 = 32'h89ABCDEF;
  localparam logic [31:0] W2 = 32'hA5C3E1B9, W3 = 32'h0F1E2D3C;
  typedef struct {
    logic [1:0]  page;
    logic [31:0] word;
    logic        blank;
  } exp_t;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         mode_auto, freeze;
  logic [1:0]   manual_sel, page_sel;
  logic         frame_start;
  logic [7:0]   display_data, display_en;
  exp_t         q[$];
  int           total = 0, passed = 0;
  seg_scan_scheduler #(.SCAN_DIV(SD), .PAGE_FRAMES(2), .NUM_SRC(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .mode_auto    (mode_auto),
    .manual_sel   (manual_sel),
    .freeze       (freeze),
    .page_sel     (page_sel),
    .frame_start  (frame_start),
    .display_data (display_data),
    .display_en   (display_en)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] seg(input logic [3:0] h);
    case (h)
      4'h0: return 8'b00000011; 4'h1: return 8'b10011111;
      4'h2: return 8'b00100101; 4'h3: return 8'b00001101;
      4'h4: return 8'b10011001; 4'h5: return 8'b01001001;
      4'h6: return 8'b01000001; 4'h7: return 8'b00011011;
      4'h8: return 8'b00000001; 4'h9: return 8'b00001001;
      4'hA: return 8'b00010001; 4'hB: return 8'b11000001;
      4'hC: return 8'b01100011; 4'hD: return 8'b10000101;
      4'hE: return 8'b01100001; default: return 8'b01110001;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic push(input logic [1:0] p, input logic [31:0] w, input logic b);
    q.push_back('{page: p, word: w, blank: b});
  endtask
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 20 * SD);
    chk("frame_start_seen", 32'(frame_start), 32'd1);
    #1;
  endtask
  task automatic blank_cycles(input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (display_en !== 8'hFF || display_data !== 8'hFF || frame_start !== 1'b0) bad++;
    end
    chk("blank_first_frame_bad_cycles", 32'(bad), 32'd0);
  endtask
  task automatic set_src(input int i, input logic [31:0] w);
    src_data[32*i +: 32] = w;
  endtask
  // Monitor: each frame_start with an outstanding expectation is checked digit by digit
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_start && q.size() > 0) begin
        e = q.pop_front();
        chk("page_sel", 32'(page_sel), 32'(e.page));
        @(negedge clk);
        chk("frame_start_width", 32'(frame_start), 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (k == 0 ? 1 : SD) @(negedge clk);
          chk($sformatf("digit%0d_en_data", k), {16'd0, display_en, display_data},
              e.blank ? 32'h0000FFFF : {16'd0, 8'(~(8'b1 << k)), seg(e.word[4*k +: 4])});
        end
      end
    end
  end
  // Stimulus: one expectation pushed ahead of every frame it describes
  initial begin
    int n;
    logic [1:0] pages [8] = '{0, 0, 1, 1, 3, 3, 0, 0};
    logic [31:0] words [4] = '{W0, W1, W2, W3};
    src_data = '0;
    set_src(0, W0); set_src(1, W1); set_src(2, W2); set_src(3, W3);
    src_valid = 4'b0001; mode_auto = 1'b0; manual_sel = 2'd0; freeze = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    push(0, W0, 0);
    blank_cycles(32);
    wait_frame(n);
    push(0, W0, 0);
    wait_frame(n);
    chk("frame_period", 32'(n), 32'(8 * SD));
    mode_auto = 1'b1; src_valid = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      push(pages[i], words[pages[i]], 0);
      wait_frame(n);
    end
    mode_auto = 1'b0; manual_sel = 2'd0; set_src(0, 32'h11111111);
    push(0, 32'h11111111, 0);
    wait_frame(n);
    repeat (10) @(negedge clk);
    #1 set_src(0, 32'h22222222);
    push(0, 32'h22222222, 0);
    wait_frame(n);
    manual_sel = 2'd2; src_valid = 4'b1011;
    push(0, 32'h0, 1);
    wait_frame(n);
    src_valid = 4'b1111;
    push(2, W2, 0);
    wait_frame(n);
    mode_auto = 1'b1;
    push(2, W2, 0);
    wait_frame(n);
    freeze = 1'b1; set_src(2, 32'h55555555);
    for (int i = 0; i < 5; i++) begin
      push(2, W2, 0);
      wait_frame(n);
    end
    freeze = 1'b0;
    push(2, 32'h55555555, 0);
    wait_frame(n);
    push(3, W3, 0);
    wait_frame(n);
    wait_frame(n);
    repeat (5 * SD) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_display_en", 32'(display_en), 32'hFF);
    chk("reset_display_data", 32'(display_data), 32'hFF);
    chk("reset_page_sel", 32'(page_sel), 32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    push(0, 32'h22222222, 0);
    blank_cycles(32);
    wait_frame(n);
    repeat (40) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
Drives the board's 8-digit multiplexed seven-segment display from several 32-bit debug sources, such as the PC, the current instruction, a register-file tap or the ALU result.
- Owns digit-scan timing through a programmable prescaler.
- Arbitrates which source (page) is shown, either round-robin on a timer or by manual select.
- Latches the chosen source only at frame boundaries, so a displayed word never tears.
- Top-level glue sits between the CPU debug taps and the display pins.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (>=2)
PAGE_FRAMES, 512, full frames per page in auto mode (>=1)
NUM_SRC, 4, number of 32-bit sources (2..8); SW = $clog2(NUM_SRC)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
src_data  in  32*NUM_SRC  source words; source i occupies bits [32*i+31:32*i]
src_valid  in  NUM_SRC  per-source valid; an invalid source is never shown
mode_auto  in  1  1 = timed round-robin paging; 0 = manual
manual_sel  in  SW  page requested in manual mode
freeze  in  1  hold the current snapshot and page; scanning continues
page_sel  out  SW  page currently latched and displayed
frame_start  out  1  one-cycle pulse at the start of each frame
display_data  out  8  active-low segments {a,b,c,d,e,f,g,dp}; dp always 1 (off)
display_en  out  8  active-low one-hot digit enable; bit k = digit k

Behaviour:
- Reset (async assert, sync deassert at the top level) takes effect immediately, including mid-frame or mid-page. Reset values:
  - prescaler=0, digit index=0, frame counter=0
  - page_sel=0, snapshot=0, blank=1
  - display_data=8'hFF, display_en=8'hFF, frame_start=0
- Prescaler counts 0..SCAN_DIV-1. tick is high in the cycle where the count equals SCAN_DIV-1; the count then wraps to 0.
- On a tick edge the digit index increments mod 8.
- Frame boundary = a tick while index==7. Boundary actions:
  - index wraps to 0
  - frame_start pulses high for exactly one cycle (the cycle index reads 0)
  - page logic updates
- Page logic at a boundary, skipped entirely while freeze=1:
  - Manual mode: the candidate page is manual_sel. Values >= NUM_SRC are treated as invalid.
  - Auto mode: the frame counter increments. When it reaches PAGE_FRAMES-1, it clears and the candidate becomes the next index after page_sel (mod NUM_SRC) with src_valid set, searching round-robin. If page_sel is the only valid source, it stays. Otherwise the candidate is page_sel.
  - Candidate valid: page_sel := candidate, snapshot := src_data[candidate], blank := 0.
  - No valid candidate: page_sel is unchanged and blank := 1.
- Changes to mode_auto, manual_sel, src_data or src_valid mid-frame have no effect until the next boundary. The snapshot is stable for a whole frame.
- The frame counter clears on any mode_auto change seen at a boundary.
- Display outputs are registered and lag the internal index by one clk:
  - display_en = ~(8'b1 << index)
  - display_data = hex_to_7seg(snapshot[4*index+3 : 4*index])
  - digit 0 shows the least significant nibble
- Blank=1 forces display_data=8'hFF and display_en=8'hFF.
- The first frame after reset is always blank, because snapshot load happens at the first boundary: 8*SCAN_DIV cycles.
- freeze asserted across a boundary means no page or snapshot change and no frame-counter increment; frame_start still pulses.

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK = 8'hFF
  - hex_to_7seg function, with 0=8'b00000011, 1=8'b10011111, ..., F=8'b01110001
  - DIGITS = 8
- One sub-module, seg_page_arbiter: combinational round-robin next-valid search over src_valid, taking current page and returning {found, next_page}.

Test Plan:
(SCAN_DIV=4, PAGE_FRAMES=2, NUM_SRC=4 unless stated)

1. Reset, manual_sel=0, src_valid=4'b0001, src0=32'h01234567.
   - Cycles 0..31: outputs all 8'hFF.
   - From the first boundary: display_en steps FE,FD,...,7F, changing every 4 clk.
   - Digit 0 shows 8'b00011011 ('7'); digit 7 shows 8'b00000011 ('0'); frame_start pulses every 32 clk.
2. Auto mode, src_valid=4'b1011.
   - page_sel sequence is 0,1,3,0, changing every 2 frames (64 clk); page 2 is never shown.
3. Change src0 from 32'h11111111 to 32'h22222222 mid-frame.
   - All remaining digits of the current frame still show '1'.
   - '2' first appears on digit 0 after the next frame_start.
4. Manual mode, manual_sel=2 with src_valid[2]=0.
   - Next frame is blank (both outputs FF) and page_sel is unchanged.
   - Set src_valid[2]=1: the following frame shows src2 and page_sel=2.
5. Auto mode with freeze=1 for 5 frames.
   - page_sel and the snapshot are constant; frame_start keeps pulsing.
   - After release, the next page change occurs 2 frames later.
6. Drop rst_n mid-frame (index=5).
   - Outputs are FF in the same cycle and page_sel=0.
   - After release, the blank first frame repeats.
